// File: rtl/rc_drive_pwm.sv
// rtl/rc_drive_pwm.sv - multi-channel RC servo/ESC pulse generator with slew, watchdog and laser fire one-shot
module rc_drive_pwm #(
  parameter int NCH           = 2,
  parameter int FRAME_TICKS   = 1000000,
  parameter int NEUTRAL_TICKS = 75000,
  parameter int SPAN_TICKS    = 25000,
  parameter int STEP_TICKS    = 2500,
  parameter int WD_FRAMES     = 25,
  parameter int FIRE_TICKS    = 5000000,
  parameter int COOL_TICKS    = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2*NCH-1:0] cmd,
  input  logic             cmd_strobe,
  input  logic             fire_req,
  output logic [NCH-1:0]   pwm_out,
  output logic             fire,
  output logic             failsafe,
  output logic             frame_start
);

  localparam int CW   = $clog2(FRAME_TICKS + 1);
  localparam int WW   = $clog2(WD_FRAMES + 1);
  localparam int TMAX = (FIRE_TICKS > COOL_TICKS) ? FIRE_TICKS : COOL_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);
  localparam logic [CW-1:0] NEU  = CW'(NEUTRAL_TICKS);
  localparam logic [CW-1:0] HI   = CW'(NEUTRAL_TICKS + SPAN_TICKS);
  localparam logic [CW-1:0] LO   = CW'(NEUTRAL_TICKS - SPAN_TICKS);
  localparam logic [CW-1:0] STEP = CW'(STEP_TICKS);
  localparam logic [WW-1:0] WD_MAX = WW'(WD_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_COOL} fire_state_t;

  logic [CW-1:0]    cnt;
  logic             wrap;
  logic [2*NCH-1:0] cmd_q;
  logic [CW-1:0]    width    [NCH];
  logic [CW-1:0]    dec      [NCH];
  logic [CW-1:0]    target   [NCH];
  logic [CW-1:0]    width_nx [NCH];
  logic [NCH-1:0]   pwm_nx;
  logic [WW-1:0]    wd, wd_nx;
  logic             failsafe_nx;
  logic [2:0]       sync;
  logic             rise;
  fire_state_t      state, state_nx;
  logic [TW-1:0]    timer, timer_nx;
  logic             fire_nx;

  assign wrap = (cnt == LAST);
  // Gated by rst_n so the pulse stays low while the counter is parked at zero in reset.
  assign frame_start = rst_n & (cnt == '0);

  // Free-running frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  // Command capture on strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cmd_q <= '0;
    else if (cmd_strobe) cmd_q <= cmd;
  end

  // Decode, failsafe override, slew step and pulse compare per channel
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      dec[i]      = NEU;
      target[i]   = NEU;
      width_nx[i] = width[i];
      pwm_nx[i]   = 1'b0;
      case (cmd_q[2*i +: 2])
        2'b01:   dec[i] = HI;
        2'b10:   dec[i] = LO;
        default: dec[i] = NEU;
      endcase
      target[i] = failsafe ? NEU : dec[i];
      if (target[i] >= width[i])
        width_nx[i] = ((target[i] - width[i]) <= STEP) ? target[i] : width[i] + STEP;
      else
        width_nx[i] = ((width[i] - target[i]) <= STEP) ? target[i] : width[i] - STEP;
      pwm_nx[i] = (cnt < width[i]);
    end
  end

  // Widths change only at the frame boundary so every pulse is whole
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) width[i] <= NEU;
    end else if (wrap) begin
      for (int i = 0; i < NCH; i++) width[i] <= width_nx[i];
    end
  end

  // Registered pulse outputs, one clock behind the compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_out <= '0;
    else        pwm_out <= pwm_nx;
  end

  // Watchdog next state; strobe beats a coincident wrap, count saturates at the limit
  always_comb begin
    wd_nx = wd;
    if (cmd_strobe)                   wd_nx = '0;
    else if (wrap && (wd != WD_MAX))  wd_nx = wd + WW'(1);
    failsafe_nx = !cmd_strobe && (failsafe || (wd_nx == WD_MAX));
  end

  // Watchdog registers; failsafe is on out of reset until the first command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd       <= '0;
      failsafe <= 1'b1;
    end else begin
      wd       <= wd_nx;
      failsafe <= failsafe_nx;
    end
  end

  // Two-stage synchroniser plus one history flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[1:0], fire_req};
  end

  assign rise = sync[1] & ~sync[2];

  // Fire FSM state, timer and registered laser enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      timer <= '0;
      fire  <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      fire  <= fire_nx;
    end
  end

  // Fire FSM next state; edges outside IDLE are dropped
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    case (state)
      S_IDLE: begin
        if (rise && !failsafe) begin
          state_nx = S_FIRE;
          timer_nx = TW'(FIRE_TICKS - 1);
        end
      end
      S_FIRE: begin
        if (failsafe || (timer == '0)) begin
          state_nx = S_COOL;
          timer_nx = TW'(COOL_TICKS - 1);
        end else begin
          timer_nx = timer - TW'(1);
        end
      end
      S_COOL: begin
        if (timer == '0) state_nx = S_IDLE;
        else             timer_nx = timer - TW'(1);
      end
      default: state_nx = S_IDLE;
    endcase
    fire_nx = (state_nx == S_FIRE);
  end

endmodule

// File: tb/tb_rc_drive_pwm.sv
// tb/tb_rc_drive_pwm.sv - directed self-checking bench for rc_drive_pwm
module tb_rc_drive_pwm;

  localparam int NCH   = 2;
  localparam int FRAME = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cmd;
  logic       cmd_strobe;
  logic       fire_req;
  logic [1:0] pwm_out;
  logic       fire;
  logic       failsafe;
  logic       frame_start;

  int n_checks = 0;
  int n_errors = 0;

  int w0, w1, nfs, fpre, fpost, nfire;
  int first_rise, second_rise, nhi_a, nhi;

  int exp_up   [4] = '{58, 66, 70, 70};
  int exp_dn   [6] = '{62, 54, 46, 38, 30, 30};
  int exp_back [5] = '{38, 46, 54, 62, 70};
  int exp_wd_w [6] = '{70, 70, 70, 62, 54, 50};
  int exp_wd_f [6] = '{0, 1, 1, 1, 1, 1};
  int exp_mix0 [2] = '{58, 66};
  int exp_mix1 [2] = '{42, 34};

  always #5 clk = ~clk;

  rc_drive_pwm #(
    .NCH(NCH), .FRAME_TICKS(FRAME), .NEUTRAL_TICKS(50), .SPAN_TICKS(20),
    .STEP_TICKS(8), .WD_FRAMES(3), .FIRE_TICKS(5), .COOL_TICKS(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_strobe(cmd_strobe),
    .fire_req(fire_req), .pwm_out(pwm_out), .fire(fire),
    .failsafe(failsafe), .frame_start(frame_start)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] c);
    cmd        = c;
    cmd_strobe = 1'b1;
    @(negedge clk);
    cmd_strobe = 1'b0;
  endtask

  task automatic wait_frame();
    int g;
    g = 0;
    while (frame_start !== 1'b1 && g < 2*FRAME) begin
      @(negedge clk);
      g++;
    end
    check("frame_wait", int'(frame_start), 1);
  endtask

  // One frame starting at a frame_start cycle; ka re-sends cmd mid-frame to feed the watchdog
  task automatic measure(input bit ka, output int m0, output int m1, output int mfs,
                         output int mpre, output int mpost, output int mfire);
    m0 = 0; m1 = 0; mfs = 0; mpre = 0; mpost = 0; mfire = 0;
    wait_frame();
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (ka && i == 10) cmd_strobe = 1'b1;
      if (ka && i == 11) cmd_strobe = 1'b0;
      m0    += int'(pwm_out[0]);
      m1    += int'(pwm_out[1]);
      mfs   += int'(frame_start);
      mfire += int'(fire);
      if (i == FRAME-2) mpre  = int'(failsafe);
      if (i == FRAME-1) mpost = int'(failsafe);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cmd = '0; cmd_strobe = 1'b0; fire_req = 1'b0;
    cycles(3);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_fire", int'(fire), 0);
    check("rst_failsafe", int'(failsafe), 1);
    check("rst_frame_start", int'(frame_start), 0);
    rst_n = 1'b1;
    #1;
    check("first_frame_start", int'(frame_start), 1);

    for (int k = 0; k < 3; k++) begin
      measure(1'b0, w0, w1, nfs, fpre, fpost, nfire);
      check($sformatf("idle_w0_%0d", k), w0, 50);
      check($sformatf("idle_w1_%0d", k), w1, 50);
      check($sformatf("idle_period_%0d", k), nfs, 1);
      check($sformatf("idle_failsafe_%0d", k), fpost, 1);
      check($sformatf("idle_fire_%0d", k), nfire, 0);
    end

    strobe(4'b0101);
    for (int k = 0; k < 4; k++) begin
      measure(1'b1, w0, w1, nfs, fpre, fpost, nfire);
      check($sformatf("up_w0_%0d", k), w0, exp_up[k]);
      check($sformatf("up_w1_%0d", k), w1, exp_up[k]);
    end
    strobe(4'b1010);
    for (int k = 0; k < 6; k++) begin
      measure(1'b1, w0, w1, nfs, fpre, fpost, nfire);
      check($sformatf("dn_w0_%0d", k), w0, exp_dn[k]);
      check($sformatf("dn_w1_%0d", k), w1, exp_dn[k]);
    end

    strobe(4'b0101);
    for (int k = 0; k < 5; k++) begin
      measure(1'b1, w0, w1, nfs, fpre, fpost, nfire);
      check($sformatf("back_w0_%0d", k), w0, exp_back[k]);
    end
    for (int k = 0; k < 6; k++) begin
      measure(1'b0, w0, w1, nfs, fpre, fpost, nfire);
      check($sformatf("wd_w0_%0d", k), w0, exp_wd_w[k]);
      check($sformatf("wd_w1_%0d", k), w1, exp_wd_w[k]);
      check($sformatf("wd_fs_%0d", k), fpost, exp_wd_f[k]);
      if (k == 1) check("wd_fs_before_trip", fpre, 0);
    end
    check("fs_before_strobe", int'(failsafe), 1);
    strobe(4'b0000);
    check("fs_clear_1clk", int'(failsafe), 0);

    fire_req = 1'b1;
    first_rise = -1; second_rise = -1; nhi_a = 0; nhi = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (fire && first_rise < 0) first_rise = j;
      if (fire && j > 28 && second_rise < 0) second_rise = j;
      if (j <= 28) nhi_a += int'(fire);
      nhi += int'(fire);
      if (j == 6)  fire_req = 1'b0;
      if (j == 10) fire_req = 1'b1;
      if (j == 14) fire_req = 1'b0;
      if (j == 26) fire_req = 1'b1;
      if (j == 32) fire_req = 1'b0;
    end
    check("fire_latency", first_rise, 3);
    check("fire_len_no_requeue", nhi_a, 5);
    check("fire_min_interval", second_rise, 29);
    check("fire_total_high", nhi, 10);
    check("fire_fs_low", int'(failsafe), 0);

    wait_frame();
    strobe(4'b0000);
    cycles(298);
    cmd_strobe = 1'b1;
    @(negedge clk);
    cmd_strobe = 1'b0;
    check("wrap_align", int'(frame_start), 1);
    check("strobe_at_wrap_fs", int'(failsafe), 0);
    cycles(200);
    check("wd_cleared_fs", int'(failsafe), 0);
    cycles(100);
    check("wd_retrip_fs", int'(failsafe), 1);

    strobe(4'b1001);
    for (int k = 0; k < 2; k++) begin
      measure(1'b1, w0, w1, nfs, fpre, fpost, nfire);
      check($sformatf("mix_w0_%0d", k), w0, exp_mix0[k]);
      check($sformatf("mix_w1_%0d", k), w1, exp_mix1[k]);
    end
    fire_req = 1'b1;
    cycles(4);
    check("pre_rst_fire", int'(fire), 1);
    check("pre_rst_pwm", int'(pwm_out), 3);
    rst_n = 1'b0;
    fire_req = 1'b0;
    #1;
    check("mid_rst_fire", int'(fire), 0);
    check("mid_rst_pwm", int'(pwm_out), 0);
    check("mid_rst_failsafe", int'(failsafe), 1);
    check("mid_rst_frame_start", int'(frame_start), 0);
    cycles(2);
    rst_n = 1'b1;
    #1;
    check("post_rst_frame_start", int'(frame_start), 1);
    measure(1'b0, w0, w1, nfs, fpre, fpost, nfire);
    check("post_rst_w0", w0, 50);
    check("post_rst_w1", w1, 50);
    check("post_rst_fs", fpost, 1);
    check("post_rst_fire", nfire, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
